// File: rtl/nvdla_dmaif_pkg.sv
// Shared definitions for the DMA interface read-request arbiter.
package nvdla_dmaif_pkg;

   localparam int AW_DEF = 64;
   localparam int NC     = 3;
   localparam int CID_W  = 2;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_e;

   // Request payload width: address plus 15-bit size field.
   function automatic int pw_of(input int aw);
      return aw + 15;
   endfunction

   // Client after id, wrapping 0,1,2,0...
   function automatic logic [CID_W-1:0] rr_next(input logic [CID_W-1:0] id);
      return (id == CID_W'(NC - 1)) ? '0 : id + 1'b1;
   endfunction

   // First eligible client at or after ptr; returns {found, id}.
   function automatic logic [CID_W:0] rr_pick(input logic [NC-1:0] el,
                                              input logic [CID_W-1:0] ptr);
      logic [CID_W:0]   r;
      logic [CID_W-1:0] c;
      r = '0;
      for (int k = NC - 1; k >= 0; k--) begin
         c = CID_W'((int'(ptr) + k) % NC);
         if (el[c]) r = {1'b1, c};
      end
      return r;
   endfunction

endpackage

// File: rtl/nvdla_dmaif_pipe_reg.sv
// One-entry valid/ready register slice; full throughput when the sink is ready.
module nvdla_dmaif_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         in_vld_i,
   output logic         in_rdy_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_vld_o,
   input  logic         out_rdy_i,
   output logic [W-1:0] out_data_o
);

   logic         vld_q;
   logic [W-1:0] data_q;

   assign in_rdy_o   = !vld_q || out_rdy_i;
   assign out_vld_o  = vld_q;
   assign out_data_o = data_q;

   // Load a new entry whenever the slot is empty or being drained this cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else if (in_rdy_o) begin
         vld_q <= in_vld_i;
         if (in_vld_i) data_q <= in_data_i;
      end
   end

endmodule

// File: rtl/nvdla_dmaif_rdreq_arb.sv
// Weighted round-robin arbiter for three DMA read clients with per-client
// outstanding-request limits and a registered output stage.
//
// state    | meaning
// ARB_IDLE | no grant owner; next grant picked from rr_q
// ARB_HOLD | owner_q fixed, burst_q beats left after the current one
module nvdla_dmaif_rdreq_arb
   import nvdla_dmaif_pkg::*;
#(
   parameter int  AW = AW_DEF,
   localparam int PW = pw_of(AW)
) (
   input  logic                nvdla_core_clk,
   input  logic                nvdla_core_rst,
   input  logic [PW-1:0]       cl0_rd_req_pd,
   input  logic                cl0_rd_req_valid,
   output logic                cl0_rd_req_ready,
   input  logic                cl0_rd_rsp_done,
   input  logic [7:0]          reg2dp_cl0_weight,
   input  logic [7:0]          reg2dp_cl0_outs_max,
   input  logic [PW-1:0]       cl1_rd_req_pd,
   input  logic                cl1_rd_req_valid,
   output logic                cl1_rd_req_ready,
   input  logic                cl1_rd_rsp_done,
   input  logic [7:0]          reg2dp_cl1_weight,
   input  logic [7:0]          reg2dp_cl1_outs_max,
   input  logic [PW-1:0]       cl2_rd_req_pd,
   input  logic                cl2_rd_req_valid,
   output logic                cl2_rd_req_ready,
   input  logic                cl2_rd_rsp_done,
   input  logic [7:0]          reg2dp_cl2_weight,
   input  logic [7:0]          reg2dp_cl2_outs_max,
   output logic [PW+CID_W-1:0] dmaif_rd_req_pd,
   output logic                dmaif_rd_req_vld,
   input  logic                dmaif_rd_req_rdy,
   output logic [NC-1:0]       dp2reg_outs_err
);

   logic [PW-1:0]    req_pd   [NC];
   logic [7:0]       wt       [NC];
   logic [7:0]       omax     [NC];
   logic [7:0]       outs_q   [NC];
   logic [7:0]       outs_d   [NC];
   logic [NC-1:0]    req_vld, rsp_done, elig, grant;
   logic [NC-1:0]    err_q, err_d;

   arb_state_e       state_q, state_d;
   logic [CID_W-1:0] owner_q, owner_d, rr_q, rr_d;
   logic [7:0]       burst_q, burst_d;

   logic [CID_W-1:0] pick_ptr, cur_own;
   logic [CID_W:0]   pk, pk_nxt;
   logic [7:0]       cur_burst;
   logic             hold_ok, cur_vld, fire, pipe_rdy;

   assign req_pd   = '{cl0_rd_req_pd, cl1_rd_req_pd, cl2_rd_req_pd};
   assign wt       = '{reg2dp_cl0_weight, reg2dp_cl1_weight, reg2dp_cl2_weight};
   assign omax     = '{reg2dp_cl0_outs_max, reg2dp_cl1_outs_max, reg2dp_cl2_outs_max};
   assign req_vld  = {cl2_rd_req_valid, cl1_rd_req_valid, cl0_rd_req_valid};
   assign rsp_done = {cl2_rd_rsp_done, cl1_rd_rsp_done, cl0_rd_rsp_done};

   assign cl0_rd_req_ready = grant[0];
   assign cl1_rd_req_ready = grant[1];
   assign cl2_rd_req_ready = grant[2];
   assign dp2reg_outs_err  = err_q;

   // Eligibility: requesting and below the outstanding limit (limit 0 masks).
   always_comb begin
      for (int n = 0; n < NC; n++) elig[n] = req_vld[n] && (outs_q[n] < omax[n]);
   end

   // Current-cycle owner: keep the held owner while eligible, otherwise
   // re-arbitrate immediately so a dropped owner costs no bubble.
   always_comb begin
      hold_ok  = (state_q == ARB_HOLD) && elig[owner_q];
      pick_ptr = (state_q == ARB_HOLD) ? rr_next(owner_q) : rr_q;
      pk       = rr_pick(elig, pick_ptr);
      if (hold_ok) begin
         cur_vld   = 1'b1;
         cur_own   = owner_q;
         cur_burst = burst_q;
      end else begin
         cur_vld   = pk[CID_W];
         cur_own   = pk[CID_W-1:0];
         cur_burst = wt[pk[CID_W-1:0]];
      end
      fire = cur_vld && pipe_rdy && !nvdla_core_rst;
      for (int n = 0; n < NC; n++) grant[n] = fire && (cur_own == CID_W'(n));
   end

   // Next arbitration state: burst bookkeeping and round-robin pointer.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      burst_d = burst_q;
      rr_d    = rr_q;
      pk_nxt  = rr_pick(elig, rr_next(cur_own));
      if (state_q == ARB_HOLD && !hold_ok) rr_d = rr_next(owner_q);
      if (fire) begin
         if (cur_burst == 8'd0) begin
            rr_d = rr_next(cur_own);
            if (pk_nxt[CID_W]) begin
               state_d = ARB_HOLD;
               owner_d = pk_nxt[CID_W-1:0];
               burst_d = wt[pk_nxt[CID_W-1:0]];
            end else begin
               state_d = ARB_IDLE;
            end
         end else begin
            state_d = ARB_HOLD;
            owner_d = cur_own;
            burst_d = cur_burst - 8'd1;
         end
      end else if (state_q == ARB_HOLD && !hold_ok) begin
         if (pk[CID_W]) begin
            owner_d = pk[CID_W-1:0];
            burst_d = wt[pk[CID_W-1:0]];
         end else begin
            state_d = ARB_IDLE;
         end
      end
   end

   // Outstanding counters; a done with nothing outstanding flags an error and
   // leaves the counter at zero.
   always_comb begin
      err_d = err_q;
      for (int n = 0; n < NC; n++) begin
         outs_d[n] = outs_q[n];
         if (grant[n] && !rsp_done[n]) begin
            outs_d[n] = outs_q[n] + 8'd1;
         end else if (!grant[n] && rsp_done[n]) begin
            if (outs_q[n] == 8'd0) err_d[n] = 1'b1;
            else                   outs_d[n] = outs_q[n] - 8'd1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         burst_q <= '0;
         rr_q    <= '0;
         err_q   <= '0;
         for (int n = 0; n < NC; n++) outs_q[n] <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         burst_q <= burst_d;
         rr_q    <= rr_d;
         err_q   <= err_d;
         for (int n = 0; n < NC; n++) outs_q[n] <= outs_d[n];
      end
   end

   nvdla_dmaif_pipe_reg #(
      .W (PW + CID_W)
   ) u_out_pipe (
      .clk_i      (nvdla_core_clk),
      .rst_i      (nvdla_core_rst),
      .in_vld_i   (fire),
      .in_rdy_o   (pipe_rdy),
      .in_data_i  ({cur_own, req_pd[cur_own]}),
      .out_vld_o  (dmaif_rd_req_vld),
      .out_rdy_i  (dmaif_rd_req_rdy),
      .out_data_o (dmaif_rd_req_pd)
   );

endmodule
